// File: rtl/operand_loader.sv
`default_nettype none
// ==========================================================================
// operand_loader : framed 8-word loader, start/done handshake with watchdog
// Rev 1.0
// ==========================================================================
module operand_loader #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [DATA_W-1:0] i1,
  output logic [DATA_W-1:0] i2,
  output logic [DATA_W-1:0] i3,
  output logic [DATA_W-1:0] i4,
  output logic [DATA_W-1:0] i5,
  output logic [DATA_W-1:0] i6,
  output logic [DATA_W-1:0] i7,
  output logic [DATA_W-1:0] i8,
  output logic              start,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err
);

  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_DRAIN = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic [DATA_W-1:0]   ops_q [8];
  logic                w_accept;

  assign in_ready  = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign start     = (state_q == S_START);
  assign res_valid = (state_q == S_OUT);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

  assign i1 = ops_q[0];
  assign i2 = ops_q[1];
  assign i3 = ops_q[2];
  assign i4 = ops_q[3];
  assign i5 = ops_q[4];
  assign i6 = ops_q[5];
  assign i7 = ops_q[6];
  assign i8 = ops_q[7];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = in_last ? S_START : S_DRAIN;
          end else if (in_last) begin
            state_d    = S_OUT;
            res_err_d  = 1'b1;
            res_data_d = '0;
          end
        end
      end
      // Overlong frame: swallow the tail so the next frame starts aligned.
      S_DRAIN: begin
        if (w_accept && in_last) begin
          state_d    = S_OUT;
          res_err_d  = 1'b1;
          res_data_d = '0;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_done) begin
          state_d    = S_OUT;
          res_err_d  = 1'b0;
          res_data_d = core_result;
        end else if (timer_q == TMAX) begin
          state_d    = S_OUT;
          res_err_d  = 1'b1;
          res_data_d = '0;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          state_d = S_LOAD;
          cnt_d   = 3'd0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      cnt_q      <= 3'd0;
      timer_q    <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) ops_q[k] <= '0;
    end else if ((state_q == S_LOAD) && w_accept) begin
      ops_q[cnt_q] <= in_data;
    end
  end

endmodule
`default_nettype wire
